// File: rtl/washer_ctrl_if.sv
// Signal bundle between the washer panel/motor driver (master) and washer_ctrl (slave).
interface washer_ctrl_if #(
  parameter int CNT_W = 6,
  parameter int CYC_W = 4
);
  logic             add;
  logic             start;
  logic             emergency;
  logic             zheng;
  logic             fan;
  logic             ledzheng;
  logic             ledfan;
  logic             ledstop;
  logic             alarm;
  logic [CNT_W-1:0] count;
  logic [CYC_W-1:0] cyc_left;

  modport master (
    output add, start, emergency,
    input  zheng, fan, ledzheng, ledfan, ledstop, alarm, count, cyc_left
  );

  modport slave (
    input  add, start, emergency,
    output zheng, fan, ledzheng, ledfan, ledstop, alarm, count, cyc_left
  );
endinterface

// File: rtl/washer_ctrl.sv
// Washer sequencer: preset number of pause/forward/pause/reverse cycles, e-stop latch, end alarm.
// Optional spin-dry finish (forward spin + pause before DONE) when WASHER_SPIN_EN is defined.
module washer_ctrl #(
  parameter int TICK_DIV  = 1,
  parameter int RUN_SEC   = 60,
  parameter int PAUSE_SEC = 5,
  parameter int ALARM_SEC = 10,
  parameter int CNT_W     = 6,
  parameter int CYC_W     = 4,
  parameter int MAX_CYC   = 15
) (
  input  logic         clk,
  input  logic         rst,
  washer_ctrl_if.slave bus
);
  localparam int               PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] RUN_LEN   = CNT_W'(RUN_SEC);
  localparam logic [CNT_W-1:0] PAUSE_LEN = CNT_W'(PAUSE_SEC);
  localparam logic [CNT_W-1:0] ALARM_LEN = CNT_W'(ALARM_SEC);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0] CYC_ONE   = {{(CYC_W-1){1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0] CYC_MAX   = CYC_W'(MAX_CYC);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    P_A   = 4'd1,
    FWD   = 4'd2,
    P_B   = 4'd3,
    REV   = 4'd4,
    DONE  = 4'd5,
    ESTOP = 4'd6
`ifdef WASHER_SPIN_EN
    , SPIN = 4'd7,
    P_S   = 4'd8
`endif
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic [CYC_W-1:0] cyc_r, cyc_s;
  logic [CYC_W-1:0] preset_r, preset_s;
  logic [PRE_W-1:0] pre_r;
  logic             add_r, add_p_r, start_r, start_p_r;
  logic             zheng_r, fan_r, ledstop_r, alarm_r;
  logic             tick_s, add_edge_s, start_edge_s, phase_end_s, launch_s;
  logic             zheng_s, fan_s;

  assign tick_s       = (pre_r == PRE_LAST);
  assign add_edge_s   = add_r & ~add_p_r;
  assign start_edge_s = start_r & ~start_p_r;
  assign phase_end_s  = tick_s && (count_r == CNT_ONE);
`ifdef WASHER_SPIN_EN
  assign zheng_s = (state_s == FWD) || (state_s == SPIN);
`else
  assign zheng_s = (state_s == FWD);
`endif
  assign fan_s = (state_s == REV);

  // Next-state, counter and preset logic; emergency overrides everything outside IDLE.
  always_comb begin
    state_s  = state_r;
    count_s  = count_r;
    cyc_s    = cyc_r;
    preset_s = preset_r;
    launch_s = 1'b0;
    if (!bus.emergency && state_r != IDLE) begin
      state_s = ESTOP;
      count_s = '0;
      cyc_s   = '0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (add_edge_s && preset_r < CYC_MAX) preset_s = preset_r + CYC_ONE;
          else preset_s = preset_r;
          // A launch beats a simultaneous DONE timeout.
          if (start_edge_s && bus.emergency && preset_r != '0) begin
            state_s  = P_A;
            count_s  = PAUSE_LEN;
            cyc_s    = preset_r;
            launch_s = 1'b1;
          end else if (state_r == DONE && tick_s) begin
            count_s = count_r - CNT_ONE;
            if (count_r == CNT_ONE) state_s = IDLE;
            else state_s = DONE;
          end else begin
            count_s = count_r;
          end
        end
        ESTOP: begin
          count_s = '0;
          cyc_s   = '0;
          if (bus.emergency) state_s = IDLE;
          else state_s = ESTOP;
        end
`ifdef WASHER_SPIN_EN
        P_A, FWD, P_B, REV, SPIN, P_S: begin
`else
        P_A, FWD, P_B, REV: begin
`endif
          count_s = tick_s ? (count_r - CNT_ONE) : count_r;
          if (phase_end_s) begin
            case (state_r)
              P_A: begin state_s = FWD; count_s = RUN_LEN;   end
              FWD: begin state_s = P_B; count_s = PAUSE_LEN; end
              P_B: begin state_s = REV; count_s = RUN_LEN;   end
              REV: begin
                if (cyc_r > CYC_ONE) begin
                  state_s = P_A;
                  count_s = PAUSE_LEN;
                  cyc_s   = cyc_r - CYC_ONE;
                end else begin
                  cyc_s = '0;
`ifdef WASHER_SPIN_EN
                  state_s = SPIN;
                  count_s = RUN_LEN;
`else
                  state_s = DONE;
                  count_s = ALARM_LEN;
`endif
                end
              end
`ifdef WASHER_SPIN_EN
              SPIN: begin state_s = P_S;  count_s = PAUSE_LEN; end
              P_S:  begin state_s = DONE; count_s = ALARM_LEN; end
`endif
              default: begin state_s = IDLE; count_s = '0; cyc_s = '0; end
            endcase
          end else begin
            state_s = state_r;
          end
        end
        default: begin
          state_s = IDLE;
          count_s = '0;
          cyc_s   = '0;
        end
      endcase
    end
  end

  // One-second prescaler, realigned to the launching start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pre_r <= '0;
    else if (launch_s || tick_s) pre_r <= '0;
    else pre_r <= pre_r + {{(PRE_W-1){1'b0}}, 1'b1};
  end

  // State, counters, edge detectors and outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      count_r   <= '0;
      cyc_r     <= '0;
      preset_r  <= '0;
      add_r     <= 1'b0;
      add_p_r   <= 1'b0;
      start_r   <= 1'b0;
      start_p_r <= 1'b0;
      zheng_r   <= 1'b0;
      fan_r     <= 1'b0;
      ledstop_r <= 1'b1;
      alarm_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      count_r   <= count_s;
      cyc_r     <= cyc_s;
      preset_r  <= preset_s;
      add_r     <= bus.add;
      add_p_r   <= add_r;
      start_r   <= bus.start;
      start_p_r <= start_r;
      zheng_r   <= zheng_s;
      fan_r     <= fan_s & ~zheng_s;
      ledstop_r <= ~(zheng_s | fan_s);
      alarm_r   <= (state_s == DONE) || (state_s == ESTOP);
    end
  end

  assign bus.zheng    = zheng_r;
  assign bus.ledzheng = zheng_r;
  assign bus.fan      = fan_r;
  assign bus.ledfan   = fan_r;
  assign bus.ledstop  = ledstop_r;
  assign bus.alarm    = alarm_r;
  assign bus.count    = count_r;
  assign bus.cyc_left = cyc_r;
endmodule
